// File: rtl/cam_pkg.sv
// Shared types for the OV5640 DVP capture path: FSM states, DVP byte width
// and a saturating 16-bit increment used by the drop counter.
package cam_pkg;

    localparam int DVP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        SKIP,
        ARM,
        ACTIVE,
        PAD,
        DROP
    } cam_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers the raw DVP pins, then produces a second, aligned stage carrying
// href/data together with the vs_start and href-fall event pulses.
module dvp_sync_edge
    import cam_pkg::*;
#(
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vsync_in,
    input  logic             href_in,
    input  logic [DVP_W-1:0] data_in,
    output logic             href_o,
    output logic [DVP_W-1:0] data_o,
    output logic             vs_start_o,
    output logic             href_fall_o
);

    logic             vs1_q, vs1_d;
    logic             href1_q, href1_d;
    logic [DVP_W-1:0] data1_q, data1_d;
    logic             vs2_q, vs2_d;
    logic             href2_q, href2_d;
    logic [DVP_W-1:0] data2_q, data2_d;
    logic             vs_start_q, vs_start_d;
    logic             href_fall_q, href_fall_d;

    // vs1 holds "VSYNC is at its active level", so polarity vanishes here.
    always_comb begin
        vs1_d       = (vsync_in == VSYNC_POL);
        href1_d     = href_in;
        data1_d     = data_in;
        vs2_d       = vs1_q;
        href2_d     = href1_q;
        data2_d     = data1_q;
        vs_start_d  = vs1_q & ~vs2_q;
        href_fall_d = href2_q & ~href1_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vs1_q       <= 1'b0;
            href1_q     <= 1'b0;
            data1_q     <= '0;
            vs2_q       <= 1'b0;
            href2_q     <= 1'b0;
            data2_q     <= '0;
            vs_start_q  <= 1'b0;
            href_fall_q <= 1'b0;
        end else begin
            vs1_q       <= vs1_d;
            href1_q     <= href1_d;
            data1_q     <= data1_d;
            vs2_q       <= vs2_d;
            href2_q     <= href2_d;
            data2_q     <= data2_d;
            vs_start_q  <= vs_start_d;
            href_fall_q <= href_fall_d;
        end
    end

    assign href_o      = href2_q;
    assign data_o      = data2_q;
    assign vs_start_o  = vs_start_q;
    assign href_fall_o = href_fall_q;

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: skips start-up frames, writes accepted frames byte-wise
// into the camera FIFO padded to whole words, and drops frames on FIFO pressure.
module ov5640_dvp_capture
    import cam_pkg::*;
#(
    parameter bit VSYNC_POL   = 1'b1,
    parameter int SKIP_FRAMES = 10,
    parameter int PACK_BYTES  = 4,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             capture_en,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [DVP_W-1:0] cam_data,
    input  logic             fifo_full,
    input  logic             fifo_almost_full,
    output logic             fifo_wr_en,
    output logic [DVP_W-1:0] fifo_wr_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_drop,
    output logic [CNT_W-1:0] last_lines,
    output logic [CNT_W-1:0] last_line_bytes,
    output logic [15:0]      drop_cnt
);

    localparam int AW = (PACK_BYTES > 1) ? $clog2(PACK_BYTES) : 1;

    logic             href_s, vs_start, href_fall;
    logic [DVP_W-1:0] data_s;

    dvp_sync_edge #(.VSYNC_POL(VSYNC_POL)) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .vsync_in   (cam_vsync),
        .href_in    (cam_href),
        .data_in    (cam_data),
        .href_o     (href_s),
        .data_o     (data_s),
        .vs_start_o (vs_start),
        .href_fall_o(href_fall)
    );

    cam_state_e       state_q, state_d;
    logic [15:0]      skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] line_byte_cnt_q, line_byte_cnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [AW-1:0]    align_q, align_d;
    logic             ovf_q, ovf_d;
    logic             silent_q, silent_d;
    logic             wr_en_q, wr_en_d;
    logic [DVP_W-1:0] wr_data_q, wr_data_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_drop_q, frame_drop_d;
    logic [CNT_W-1:0] last_lines_q, last_lines_d;
    logic [CNT_W-1:0] last_line_bytes_q, last_line_bytes_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [AW-1:0] align_inc(input logic [AW-1:0] v);
        return (v == AW'(PACK_BYTES - 1)) ? '0 : v + AW'(1);
    endfunction

    always_comb begin
        state_d           = state_q;
        skip_cnt_d        = skip_cnt_q;
        line_cnt_d        = line_cnt_q;
        line_byte_cnt_d   = line_byte_cnt_q;
        line_len_d        = line_len_q;
        align_d           = align_q;
        ovf_d             = ovf_q;
        silent_d          = silent_q;
        wr_en_d           = 1'b0;
        wr_data_d         = '0;
        frame_start_d     = 1'b0;
        frame_done_d      = 1'b0;
        frame_drop_d      = 1'b0;
        last_lines_d      = last_lines_q;
        last_line_bytes_d = last_line_bytes_q;
        drop_cnt_d        = drop_cnt_q;
        take              = 1'b0;

        case (state_q)
            IDLE: if (capture_en) state_d = WAIT_VS;
            WAIT_VS: begin
                if (vs_start) begin
                    skip_cnt_d = '0;
                    state_d    = (SKIP_FRAMES > 0) ? SKIP : ARM;
                end
            end
            SKIP: begin
                if (vs_start) begin
                    if (skip_cnt_q == 16'(SKIP_FRAMES - 1)) state_d = ARM;
                    else skip_cnt_d = skip_cnt_q + 16'd1;
                end
            end
            ARM: begin
                // Counters are already clear here; every path into ARM leaves them so.
                if (href_s) begin
                    if (fifo_almost_full || !capture_en) begin
                        silent_d = !capture_en;
                        state_d  = DROP;
                    end else begin
                        take    = 1'b1;
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                take = href_s;
                if (href_fall) begin
                    line_cnt_d      = sat_inc(line_cnt_q);
                    line_len_d      = line_byte_cnt_q;
                    line_byte_cnt_d = '0;
                end
                if (vs_start) state_d = PAD;
            end
            PAD: begin
                if (align_q != '0) begin
                    wr_en_d = 1'b1;
                    align_d = align_inc(align_q);
                end else begin
                    if (ovf_q) begin
                        frame_drop_d = 1'b1;
                        drop_cnt_d   = sat_inc16(drop_cnt_q);
                    end else begin
                        frame_done_d      = 1'b1;
                        last_lines_d      = line_cnt_q;
                        last_line_bytes_d = line_len_q;
                    end
                    line_cnt_d      = '0;
                    line_byte_cnt_d = '0;
                    line_len_d      = '0;
                    ovf_d           = 1'b0;
                    state_d         = capture_en ? ARM : IDLE;
                end
            end
            DROP: begin
                if (vs_start) begin
                    silent_d = 1'b0;
                    if (silent_q) begin
                        state_d = IDLE;
                    end else begin
                        frame_drop_d = 1'b1;
                        drop_cnt_d   = sat_inc16(drop_cnt_q);
                        state_d      = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte lost to fifo_full is never written or aligned; later bytes are ignored.
        if (take) begin
            line_byte_cnt_d = sat_inc(line_byte_cnt_q);
            if (!ovf_q) begin
                if (fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d       = 1'b1;
                    wr_data_d     = data_s;
                    align_d       = align_inc(align_q);
                    frame_start_d = (state_q == ARM);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q           <= IDLE;
            skip_cnt_q        <= '0;
            line_cnt_q        <= '0;
            line_byte_cnt_q   <= '0;
            line_len_q        <= '0;
            align_q           <= '0;
            ovf_q             <= 1'b0;
            silent_q          <= 1'b0;
            wr_en_q           <= 1'b0;
            wr_data_q         <= '0;
            frame_start_q     <= 1'b0;
            frame_done_q      <= 1'b0;
            frame_drop_q      <= 1'b0;
            last_lines_q      <= '0;
            last_line_bytes_q <= '0;
            drop_cnt_q        <= '0;
        end else begin
            state_q           <= state_d;
            skip_cnt_q        <= skip_cnt_d;
            line_cnt_q        <= line_cnt_d;
            line_byte_cnt_q   <= line_byte_cnt_d;
            line_len_q        <= line_len_d;
            align_q           <= align_d;
            ovf_q             <= ovf_d;
            silent_q          <= silent_d;
            wr_en_q           <= wr_en_d;
            wr_data_q         <= wr_data_d;
            frame_start_q     <= frame_start_d;
            frame_done_q      <= frame_done_d;
            frame_drop_q      <= frame_drop_d;
            last_lines_q      <= last_lines_d;
            last_line_bytes_q <= last_line_bytes_d;
            drop_cnt_q        <= drop_cnt_d;
        end
    end

    assign fifo_wr_en      = wr_en_q;
    assign fifo_wr_data    = wr_data_q;
    assign frame_start     = frame_start_q;
    assign frame_done      = frame_done_q;
    assign frame_drop      = frame_drop_q;
    assign last_lines      = last_lines_q;
    assign last_line_bytes = last_line_bytes_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Directed bench for ov5640_dvp_capture with VSYNC active-low and two skipped
// start-up frames; inputs change and outputs are sampled on the falling edge.
module tb_ov5640_dvp_capture;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             capture_en = 1'b0;
    logic             cam_vsync = 1'b1;
    logic             cam_href = 1'b0;
    logic [7:0]       cam_data = 8'h00;
    logic             fifo_full = 1'b0;
    logic             fifo_almost_full = 1'b0;
    logic             fifo_wr_en;
    logic [7:0]       fifo_wr_data;
    logic             frame_start;
    logic             frame_done;
    logic             frame_drop;
    logic [CNT_W-1:0] last_lines;
    logic [CNT_W-1:0] last_line_bytes;
    logic [15:0]      drop_cnt;

    always #5 clk = ~clk;

    ov5640_dvp_capture #(
        .VSYNC_POL  (1'b0),
        .SKIP_FRAMES(2),
        .PACK_BYTES (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .capture_en      (capture_en),
        .cam_vsync       (cam_vsync),
        .cam_href        (cam_href),
        .cam_data        (cam_data),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .frame_drop      (frame_drop),
        .last_lines      (last_lines),
        .last_line_bytes (last_line_bytes),
        .drop_cnt        (drop_cnt)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_start = 0;
    int         n_done = 0;
    int         n_drop = 0;

    always @(negedge clk) begin
        if (fifo_wr_en) got_q.push_back(fifo_wr_data);
        if (frame_start) n_start++;
        if (frame_done) n_done++;
        if (frame_drop) n_drop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse();
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        tick(3);
        cam_vsync = 1'b1;
        tick(8);
    endtask

    // full_at raises fifo_full while byte full_at is driven, losing byte full_at-2.
    task automatic send_line(input int n, input logic [7:0] base, input bit keep, input int full_at);
        for (int i = 0; i < n; i++) begin
            cam_href  = 1'b1;
            cam_data  = base + 8'(i);
            fifo_full = (i == full_at);
            if (keep) exp_q.push_back(cam_data);
            tick(1);
        end
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        fifo_full = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input int lines, input int n, input logic [7:0] base, input bit keep);
        for (int l = 0; l < lines; l++) send_line(n, base + 8'(l * 16), keep, -1);
    endtask

    task automatic check_frame(input string tag, input int n_wr, input int n_st, input int n_dn, input int n_dr);
        check({tag, " writes"}, got_q.size(), n_wr);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, " byte"}, got_q[i], exp_q[i]);
        check({tag, " frame_start"}, n_start, n_st);
        check({tag, " frame_done"}, n_done, n_dn);
        check({tag, " frame_drop"}, n_drop, n_dr);
        got_q.delete();
        exp_q.delete();
        n_start = 0;
        n_done  = 0;
        n_drop  = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " wr_en"}, fifo_wr_en, 0);
        check({tag, " wr_data"}, fifo_wr_data, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_drop"}, frame_drop, 0);
        check({tag, " last_lines"}, last_lines, 0);
        check({tag, " last_line_bytes"}, last_line_bytes, 0);
        check({tag, " drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        tick(4);
        check_zero("reset");
        rstn       = 1'b1;
        capture_en = 1'b1;
        tick(4);

        // Two start-up frames skipped, then two 3x8 frames captured.
        vs_pulse();
        send_frame(3, 8, 8'h10, 1'b0);
        vs_pulse();
        send_frame(3, 8, 8'h40, 1'b0);
        vs_pulse();
        check_frame("skip", 0, 0, 0, 0);
        send_frame(3, 8, 8'h80, 1'b1);
        vs_pulse();
        check_frame("frame3", 24, 1, 1, 0);
        check("frame3 last_lines", last_lines, 3);
        check("frame3 last_line_bytes", last_line_bytes, 8);
        send_frame(3, 8, 8'hC0, 1'b1);
        vs_pulse();
        check_frame("frame4", 24, 1, 1, 0);

        // 21-byte frame gets three zero pad bytes.
        send_frame(3, 7, 8'h20, 1'b1);
        repeat (3) exp_q.push_back(8'h00);
        vs_pulse();
        check_frame("pad21", 24, 1, 1, 0);
        check("pad21 last_lines", last_lines, 3);
        check("pad21 last_line_bytes", last_line_bytes, 7);

        // Almost-full at the first href drops the whole frame.
        fifo_almost_full = 1'b1;
        send_frame(3, 8, 8'h50, 1'b0);
        fifo_almost_full = 1'b0;
        vs_pulse();
        check_frame("afull", 0, 0, 0, 1);
        check("afull drop_cnt", drop_cnt, 1);

        // One-cycle fifo_full loses byte 5 of line 1: 5 bytes kept, 3 pad.
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h60 + 8'(i));
        send_line(8, 8'h60, 1'b0, 7);
        send_line(8, 8'h70, 1'b0, -1);
        send_line(8, 8'h80, 1'b0, -1);
        repeat (3) exp_q.push_back(8'h00);
        vs_pulse();
        check_frame("ovf", 8, 1, 0, 1);
        check("ovf drop_cnt", drop_cnt, 2);
        check("ovf last_line_bytes", last_line_bytes, 7);

        // capture_en falls mid-frame: frame completes, next frame ignored.
        send_line(8, 8'h30, 1'b1, -1);
        capture_en = 1'b0;
        send_line(8, 8'h38, 1'b1, -1);
        send_line(8, 8'h48, 1'b1, -1);
        vs_pulse();
        check_frame("en_off", 24, 1, 1, 0);
        check("en_off last_line_bytes", last_line_bytes, 8);
        check("en_off last_lines", last_lines, 3);
        send_frame(2, 4, 8'h90, 1'b0);
        vs_pulse();
        check_frame("idle", 0, 0, 0, 0);
        check("idle drop_cnt", drop_cnt, 2);

        // Re-arm (two frames skipped again), then check the two-edge latency.
        capture_en = 1'b1;
        tick(2);
        vs_pulse();
        vs_pulse();
        vs_pulse();
        cam_href = 1'b1;
        cam_data = 8'hA5;
        tick(1);
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick(1);
        check("lat k+1 wr_en", fifo_wr_en, 0);
        tick(1);
        check("lat k+2 wr_en", fifo_wr_en, 1);
        check("lat k+2 wr_data", fifo_wr_data, 8'hA5);
        check("lat k+2 frame_start", frame_start, 1);
        tick(4);

        // Reset in the middle of a line.
        for (int i = 0; i < 4; i++) begin
            cam_href = 1'b1;
            cam_data = 8'h11 + 8'(i);
            tick(1);
        end
        check("pre_rst wr_en", fifo_wr_en, 1);
        rstn = 1'b0;
        tick(1);
        check_zero("mid_rst");
        rstn       = 1'b1;
        cam_href   = 1'b0;
        capture_en = 1'b0;
        tick(3);
        got_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
